// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared types and constants for the CPU-to-Wishbone bridge.
// Revision : 1.0
// ============================================================================
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic [3:0] WB_SEL_ALL      = 4'b1111;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bus_timeout_counter
// Purpose  : Counts BUSY cycles; flags the cycle in which the limit is reached.
// Revision : 1.0
// ============================================================================
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Expiry is flagged during the TIMEOUT_CYCLES-th enabled cycle itself.
  assign expired_o = enable_i && (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wishbone_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_bridge
// Purpose  : Turns single-cycle CPU loads/stores into Wishbone B4 classic cycles.
// Revision : 1.0
// ============================================================================
module wishbone_bridge
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read_enable,
  input  logic        cpu_write_enable,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic        bus_error,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err
);

  bridge_state_t state_q;
  logic          cyc_q;
  logic          we_q;
  logic          bus_error_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [31:0]   rdata_q;

  logic w_request;
  logic w_misaligned;
  logic w_expired;
  logic w_in_busy;

  assign w_request    = cpu_read_enable | cpu_write_enable;
  assign w_misaligned = (cpu_address[1:0] & WORD_ALIGN_MASK) != 2'b00;
  assign w_in_busy    = (state_q == BUSY);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (!w_in_busy),
    .enable_i (w_in_busy),
    .expired_o(w_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rdata_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_request) begin
            rdata_q <= '0;
            if (w_misaligned) begin
              bus_error_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              adr_q   <= {cpu_address[31:2], 2'b00};
              dat_q   <= cpu_write_data;
              we_q    <= cpu_write_enable;
              cyc_q   <= 1'b1;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // An error beats a simultaneous ack; a late ack beats the timeout.
          if (wb_err || (w_expired && !wb_ack)) begin
            cyc_q       <= 1'b0;
            rdata_q     <= '0;
            bus_error_q <= 1'b1;
            state_q     <= DONE;
          end else if (wb_ack) begin
            cyc_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= wb_dat_i;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = w_request;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign cpu_read_data = (state_q == DONE) ? rdata_q : 32'h0;
  assign bus_error     = bus_error_q;
  assign wb_cyc        = cyc_q;
  assign wb_stb        = cyc_q;
  assign wb_we         = we_q;
  assign wb_adr        = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel        = cyc_q ? WB_SEL_ALL : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_bridge
// Purpose  : Directed bench with a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wishbone_bridge;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_address = '0;
  logic        cpu_read_enable = 1'b0;
  logic        cpu_write_enable = 1'b0;
  logic [31:0] cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic        stall;
  logic        bus_error;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  wishbone_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_address     (cpu_address),
    .cpu_read_enable (cpu_read_enable),
    .cpu_write_enable(cpu_write_enable),
    .cpu_write_data  (cpu_write_data),
    .cpu_read_data   (cpu_read_data),
    .stall           (stall),
    .bus_error       (bus_error),
    .wb_cyc          (wb_cyc),
    .wb_stb          (wb_stb),
    .wb_we           (wb_we),
    .wb_adr          (wb_adr),
    .wb_dat_o        (wb_dat_o),
    .wb_sel          (wb_sel),
    .wb_dat_i        (wb_dat_i),
    .wb_ack          (wb_ack),
    .wb_err          (wb_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight access, described by what the CPU sees.
  bit          m_bus = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_fresh = 1'b1;
  bit          m_rd_check = 1'b0;
  bit          m_we = 1'b0;
  int          m_waited = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_bus      <= 1'b0;
      m_done     <= 1'b0;
      m_err      <= 1'b0;
      m_fresh    <= 1'b1;
      m_rd_check <= 1'b0;
      m_waited   <= 0;
      m_rd       <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_bus) begin
      m_waited <= m_waited + 1;
      if (wb_err || (!wb_ack && (m_waited + 1 == TO))) begin
        m_bus <= 1'b0; m_done <= 1'b1; m_err <= 1'b1; m_rd <= '0; m_rd_check <= 1'b1;
      end else if (wb_ack) begin
        m_bus <= 1'b0; m_done <= 1'b1; m_rd <= wb_dat_i; m_rd_check <= !m_we;
      end
    end else if (cpu_read_enable || cpu_write_enable) begin
      if (cpu_address[1:0] != 2'b00) begin
        m_done <= 1'b1; m_err <= 1'b1; m_rd <= '0; m_rd_check <= 1'b1;
      end else begin
        m_bus <= 1'b1; m_fresh <= 1'b0; m_waited <= 0;
        m_we  <= cpu_write_enable;
        m_adr <= cpu_address;
        m_dat <= cpu_write_data;
      end
    end
  end

  always @(negedge clock) begin
    logic req;
    req = cpu_read_enable | cpu_write_enable;
    check("stall", {31'b0, stall}, {31'b0, (m_bus ? 1'b1 : (m_done ? 1'b0 : req))});
    check("wb_cyc", {31'b0, wb_cyc}, {31'b0, m_bus});
    check("wb_stb", {31'b0, wb_stb}, {31'b0, m_bus});
    check("wb_sel", {28'b0, wb_sel}, m_bus ? 32'hF : 32'h0);
    check("bus_error", {31'b0, bus_error}, {31'b0, m_err});
    if (!m_done) check("rdata_idle", cpu_read_data, 32'h0);
    else if (m_rd_check) check("rdata_done", cpu_read_data, m_rd);
    if (m_bus) begin
      check("wb_we", {31'b0, wb_we}, {31'b0, m_we});
      check("wb_adr", wb_adr, m_adr);
      check("wb_dat_o", wb_dat_o, m_dat);
    end else if (m_fresh) begin
      check("wb_we_rst", {31'b0, wb_we}, 32'h0);
      check("wb_adr_rst", wb_adr, 32'h0);
      check("wb_dat_o_rst", wb_dat_o, 32'h0);
    end
  end

  // Called at posedge+1; leaves at posedge+1 after the DONE cycle.
  // The request is held through DONE, as a stalled CPU would.
  task automatic access(input bit re, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int term_at, input bit t_ack, input bit t_err, input logic [31:0] sd,
                        output int lat, output int stb_n, output logic [31:0] rd);
    lat = 0; stb_n = 0; rd = 32'hFFFF_FFFF;
    cpu_read_enable = re; cpu_write_enable = we; cpu_address = a; cpu_write_data = d;
    for (int k = 0; k < 40; k++) begin
      wb_ack   = (k == term_at) && t_ack;
      wb_err   = (k == term_at) && t_err;
      wb_dat_i = (k == term_at) ? sd : 32'h0BAD_0BAD;
      #3;
      if (wb_stb) stb_n++;
      if (!stall) begin
        lat = k + 1;
        rd  = cpu_read_data;
      end
      @(posedge clock); #1;
      if (lat != 0) break;
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    cpu_read_enable = 1'b0; cpu_write_enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stb_n;
    logic [31:0] rd;

    repeat (2) @(posedge clock);
    #1;
    check("reset wb_cyc", {31'b0, wb_cyc}, 32'h0);
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset rdata", cpu_read_data, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Zero-wait read
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 1'b0, 32'hDEADBEEF, lat, stb_n, rd);
    check("rd0 latency", lat, 3);
    check("rd0 stb cycles", stb_n, 1);
    check("rd0 data", rd, 32'hDEADBEEF);

    // Write with three wait states; ack lands on the last allowed cycle
    access(1'b0, 1'b1, 32'h204, 32'h12345678, 4, 1'b1, 1'b0, 32'h0, lat, stb_n, rd);
    check("wr latency", lat, 6);
    check("wr stb cycles", stb_n, 4);
    check("wr bus_error", {31'b0, bus_error}, 32'h0);

    // Non-memory instruction: no stall
    cpu_address = 32'h1234;
    #3;
    check("nomem stall", {31'b0, stall}, 32'h0);
    @(posedge clock); #1;

    // Timeout: slave never answers
    access(1'b1, 1'b0, 32'h400, 32'h0, -1, 1'b0, 1'b0, 32'h0, lat, stb_n, rd);
    check("to stb cycles", stb_n, TO);
    check("to latency", lat, TO + 2);
    check("to data", rd, 32'h0);
    check("to bus_error", {31'b0, bus_error}, 32'h1);

    // Back-to-back good read; error stays sticky
    access(1'b1, 1'b0, 32'h104, 32'h0, 2, 1'b1, 1'b0, 32'hCAFEF00D, lat, stb_n, rd);
    check("rd1 latency", lat, 4);
    check("rd1 data", rd, 32'hCAFEF00D);
    check("rd1 bus_error", {31'b0, bus_error}, 32'h1);

    // Misaligned read
    access(1'b1, 1'b0, 32'h102, 32'h0, 1, 1'b1, 1'b0, 32'h5555_5555, lat, stb_n, rd);
    check("mis stb cycles", stb_n, 0);
    check("mis latency", lat, 2);
    check("mis data", rd, 32'h0);

    // Reset in the middle of a BUSY cycle
    cpu_read_enable = 1'b1; cpu_address = 32'h100;
    @(posedge clock); #1;
    #2;
    reset = 1'b1;
    cpu_read_enable = 1'b0;
    #1;
    check("midrst wb_cyc", {31'b0, wb_cyc}, 32'h0);
    check("midrst wb_stb", {31'b0, wb_stb}, 32'h0);
    check("midrst bus_error", {31'b0, bus_error}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 1'b0, 32'h600DF00D, lat, stb_n, rd);
    check("postrst latency", lat, 3);
    check("postrst data", rd, 32'h600DF00D);

    // Both enables high, err with ack
    access(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 1, 1'b1, 1'b1, 32'h7777_7777, lat, stb_n, rd);
    check("both latency", lat, 3);
    check("both data", rd, 32'h0);
    check("both bus_error", {31'b0, bus_error}, 32'h1);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wishbone_bridge.md
# wishbone_bridge

Bridges the CPU's single-cycle data bus to a Wishbone B4 classic master port. It sits directly downstream of `cpu`: it takes the data address, write enable and write data, plus an added read enable, and drives one Wishbone cycle per access. It returns read data and stalls the CPU (holds PC and register writeback) until the access completes. Hung slaves are caught by a timeout.

## Interface
- `TIMEOUT_CYCLES`, 16, max BUSY cycles waiting for `wb_ack`/`wb_err` before aborting; ≥ 1, fits `$clog2(TIMEOUT_CYCLES+1)` counter.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_address`  in  32  byte address (ALU result).
- `cpu_read_enable`  in  1  load request this cycle.
- `cpu_write_enable`  in  1  store request this cycle.
- `cpu_write_data`  in  32  store data.
- `cpu_read_data`  out  32  load data, valid in DONE only.
- `stall`  out  1  CPU must not advance while high.
- `bus_error`  out  1  sticky; set on err/timeout/misalign, cleared by reset only.
- `wb_cyc`, `wb_stb`  out  1 each  Wishbone cycle/strobe, registered.
- `wb_we`  out  1  registered write flag.
- `wb_adr`  out  32  registered byte address, `[1:0]` always 0.
- `wb_dat_o`  out  32  registered write data.
- `wb_sel`  out  4  always `4'b1111` during a cycle, `0` otherwise.
- `wb_dat_i`  in  32  slave read data.
- `wb_ack`, `wb_err`  in  1 each  slave termination.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: request = `cpu_read_enable | cpu_write_enable`. `stall` = request (combinational). On request with `cpu_address[1:0]==0`: latch address/data; `wb_we` = write; assert `wb_cyc`/`wb_stb`; clear timeout counter → BUSY. Both enables high: write wins. Misaligned: no bus cycle; set `bus_error`; read data register = 0 → DONE.
- BUSY: `stall`=1, all `wb_*` held stable; counter increments each cycle.
  - `wb_ack`: capture `wb_dat_i` (reads only), drop cyc/stb → DONE.
  - `wb_err` (or err+ack together): error wins; read data = 0, set `bus_error`, drop cyc/stb → DONE.
  - Counter reaches `TIMEOUT_CYCLES` with no termination: same as `wb_err`.
- DONE: `stall`=0, `cpu_read_data` = captured word; CPU completes the instruction this edge → IDLE unconditionally. Any request present in DONE is ignored, since it belongs to the current instruction and has already been served.
- `cpu_read_data` = 0 outside DONE.

## Timing
- Reset (async, immediate): state IDLE; `wb_cyc`=`wb_stb`=`wb_we`=0; `wb_adr`=`wb_dat_o`=0; `wb_sel`=0; `cpu_read_data`=0; `bus_error`=0; counter 0. `stall` follows IDLE rule.
- Reset mid-BUSY aborts the cycle: cyc/stb fall asynchronously, with no DONE and no data returned.
- Zero-wait slave (ack in first BUSY cycle): 3 cycles per access: C0 IDLE stall=1; C1 BUSY stb=1, ack; C2 DONE stall=0. Each slave wait state adds 1 cycle.
- Timeout: stb high exactly `TIMEOUT_CYCLES` cycles, then DONE.
- Back-to-back accesses: strobe is low for at least 2 cycles between accesses (DONE, IDLE).
- Non-memory instructions: IDLE with no request gives `stall`=0, so there is zero overhead.

## Structure
- Package `bus_pkg`: `bridge_state_t` enum (IDLE, BUSY, DONE), `WB_SEL_ALL = 4'b1111`, `WORD_ALIGN_MASK = 2'b11`.
- One sub-module `bus_timeout_counter` (clear, enable, `expired` output, parameterised by `TIMEOUT_CYCLES`). The FSM and datapath registers live in `wishbone_bridge`.
- `cpu` gains a `stall` input gating the PC and register write enable; that change is out of scope here.

## Test plan
- Read, zero-wait: addr 0x100, slave acks C1 with 0xDEADBEEF → C1 `wb_stb`=1, `wb_we`=0, `wb_adr`=0x100; C2 stall=0, `cpu_read_data`=0xDEADBEEF.
- Write, 3 wait states: addr 0x204, data 0x12345678 → stb/we/adr/dat_o stable 4 cycles, `wb_sel`=1111; DONE on 5th cycle after request; `bus_error`=0.
- Timeout (`TIMEOUT_CYCLES`=4), slave never acks → stb high 4 cycles, then DONE with read data 0; `bus_error`=1 and stays 1 through later good accesses.
- Misaligned read at 0x102 → no `wb_cyc` ever; next cycle DONE, `bus_error`=1, data 0.
- Reset asserted mid-BUSY, between edges → `wb_cyc`/`wb_stb` fall before next edge; after release, a read of 0x100 completes normally in 3 cycles.
- Read+write both high, addr 0x300 → `wb_we`=1; `wb_err` together with ack → error path, `bus_error`=1.
